// File: rtl/vga_sync_gen_if.sv
// -----------------------------------------------------------------------------
// vga_sync_gen_if
//   Raster timing bundle from the sync generator to the colour stages.
//
//   o_hpos        [9:CONV] horizontal pixel position (hcount, downscaled)
//   o_vpos        [9:CONV] vertical pixel position (vcount, downscaled)
//   o_hsync       horizontal sync, active level set by the generator
//   o_vsync       vertical sync, active level set by the generator
//   o_display_on  high inside the visible area
//   o_line_tick   one-cycle pulse on the last pixel of each line
//   o_frame_tick  one-cycle pulse on the last pixel of each frame
//   o_frame       free-running 8-bit frame counter
//
//   master : the timing generator (drives everything)
//   slave  : a colour / pixel stage (observes everything)
// -----------------------------------------------------------------------------
interface vga_sync_gen_if #(
  parameter int CONV = 0
);
  logic [9:CONV] o_hpos;
  logic [9:CONV] o_vpos;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_display_on;
  logic          o_line_tick;
  logic          o_frame_tick;
  logic [7:0]    o_frame;

  modport master (
    output o_hpos, o_vpos, o_hsync, o_vsync,
           o_display_on, o_line_tick, o_frame_tick, o_frame
  );

  modport slave (
    input  o_hpos, o_vpos, o_hsync, o_vsync,
           o_display_on, o_line_tick, o_frame_tick, o_frame
  );
endinterface

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   Raster timing generator running at the pixel clock. Walks a 10-bit
//   horizontal counter across each line and a 10-bit vertical counter down
//   each frame, and derives sync pulses, display enable, line/frame strobes
//   and an 8-bit frame counter for animation.
//
//   clk   pixel clock
//   rst   synchronous reset, active-high
//   vga   timing bundle (master side), see vga_sync_gen_if
//
//   Positions are bit-slices of the counters: CONV drops low bits to give a
//   coarser grid. The counters themselves never depend on CONV.
// -----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int CONV      = 0,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Timing boundaries sized to the counters so every compare is 10-bit.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS_END  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [9:0] hcount, vcount;
  logic [9:0] hcount_nx, vcount_nx;
  logic [7:0] frame;
  logic       hsync_q, vsync_q;
  logic       h_end, v_end;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    h_end     = (hcount == H_LAST);
    v_end     = (vcount == V_LAST);
    hcount_nx = hcount + 10'd1;
    vcount_nx = vcount;
    if (h_end) begin
      hcount_nx = '0;
      vcount_nx = v_end ? '0 : vcount + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      hcount  <= '0;
      vcount  <= '0;
      frame   <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else begin
      hcount <= hcount_nx;
      vcount <= vcount_nx;
      if (h_end && v_end) begin
        frame <= frame + 8'd1;
      end
      // Syncs are decoded from the next-state counters so the registered
      // pulse lines up exactly with the position that produced it.
      hsync_q <= (hcount_nx >= HS_START && hcount_nx < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync_q <= (vcount_nx >= VS_START && vcount_nx < VS_END) ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign vga.o_hpos       = hcount[9:CONV];
  assign vga.o_vpos       = vcount[9:CONV];
  assign vga.o_hsync      = hsync_q;
  assign vga.o_vsync      = vsync_q;
  assign vga.o_display_on = (hcount < H_VIS_END) && (vcount < V_VIS_END);
  assign vga.o_line_tick  = h_end;
  assign vga.o_frame_tick = h_end && v_end;
  assign vga.o_frame      = frame;

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//   Two instances share one clock:
//     dut_a : standard 640x480 timing, CONV=0 (reset, one full line, mid-line reset)
//     dut_b : shrunken 16x10 raster, CONV=1 (full frame, slicing, mid-frame
//             reset, 256-frame counter wrap)
//   dut_b timing: H 10+2+3+1 = 16 (hsync h=12..14), V 6+1+2+1 = 10
//   (vsync lines 7..8), 160 cycles per frame.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst_a, rst_b;

  always #5 clk = ~clk;

  vga_sync_gen_if #(.CONV(0)) bus_a ();
  vga_sync_gen_if #(.CONV(1)) bus_b ();

  vga_sync_gen #(.CONV(0)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (bus_a)
  );

  vga_sync_gen #(
    .CONV(1),
    .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(1),
    .V_DISPLAY(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1'b0)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (bus_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Scan accumulators
  int hs_low, hs_first, hs_last, vs_low, vs_first, vs_last;
  int de_fall, lt_cnt, lt_at, ft_cnt, ft_at, pos_err, de_err, frame_at_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance n clock edges and settle just after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;

    // ---------------- dut_a: reset held 3 cycles ----------------
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("a_rst_hpos",  32'(bus_a.o_hpos), 32'd0);
      check("a_rst_vpos",  32'(bus_a.o_vpos), 32'd0);
      check("a_rst_hsync", 32'(bus_a.o_hsync), 32'd1);
      check("a_rst_vsync", 32'(bus_a.o_vsync), 32'd1);
      check("a_rst_de",    32'(bus_a.o_display_on), 32'd1);
      check("a_rst_frame", 32'(bus_a.o_frame), 32'd0);
      check("a_rst_lt",    32'(bus_a.o_line_tick), 32'd0);
      check("a_rst_ft",    32'(bus_a.o_frame_tick), 32'd0);
    end
    rst_a = 1'b0;
    check("a_rel_hpos", 32'(bus_a.o_hpos), 32'd0);
    check("a_rel_hsync", 32'(bus_a.o_hsync), 32'd1);
    step(1);
    check("a_first_hpos", 32'(bus_a.o_hpos), 32'd1);
    check("a_first_vpos", 32'(bus_a.o_vpos), 32'd0);

    // ---------------- dut_a: one full line ----------------
    hs_low = 0; hs_first = -1; hs_last = -1; vs_low = 0;
    de_fall = -1; lt_cnt = 0; lt_at = -1; ft_cnt = 0; pos_err = 0;
    for (int h = 1; h < 800; h++) begin
      if (32'(bus_a.o_hpos) != 32'(h) || bus_a.o_vpos != 10'd0) pos_err++;
      if (bus_a.o_hsync == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = h;
        hs_last = h;
      end
      if (bus_a.o_vsync == 1'b0) vs_low++;
      if (!bus_a.o_display_on && de_fall < 0) de_fall = h;
      if (bus_a.o_line_tick) begin
        lt_cnt++;
        lt_at = h;
      end
      if (bus_a.o_frame_tick) ft_cnt++;
      step(1);
    end
    check("a_line_pos_err",  32'(pos_err), 32'd0);
    check("a_hsync_len",     32'(hs_low), 32'd96);
    check("a_hsync_first",   32'(hs_first), 32'd656);
    check("a_hsync_last",    32'(hs_last), 32'd751);
    check("a_vsync_line0",   32'(vs_low), 32'd0);
    check("a_de_fall",       32'(de_fall), 32'd640);
    check("a_lt_count",      32'(lt_cnt), 32'd1);
    check("a_lt_at",         32'(lt_at), 32'd799);
    check("a_ft_line0",      32'(ft_cnt), 32'd0);
    check("a_wrap_hpos",     32'(bus_a.o_hpos), 32'd0);
    check("a_wrap_vpos",     32'(bus_a.o_vpos), 32'd1);

    // ---------------- dut_a: reset mid-line at (300,2) ----------------
    step(1100);
    check("a_mid_hpos", 32'(bus_a.o_hpos), 32'd300);
    check("a_mid_vpos", 32'(bus_a.o_vpos), 32'd2);
    rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    check("a_mrst_hpos",  32'(bus_a.o_hpos), 32'd0);
    check("a_mrst_vpos",  32'(bus_a.o_vpos), 32'd0);
    check("a_mrst_hsync", 32'(bus_a.o_hsync), 32'd1);
    step(1);
    check("a_resume_hpos", 32'(bus_a.o_hpos), 32'd1);

    // ---------------- dut_b: one full small frame ----------------
    rst_b = 1'b0;
    vs_low = 0; vs_first = -1; vs_last = -1;
    hs_low = 0; ft_cnt = 0; ft_at = -1; lt_cnt = 0; pos_err = 0; de_err = 0;
    for (int c = 0; c < 160; c++) begin
      int h, v;
      h = c % 16;
      v = c / 16;
      if (32'(bus_b.o_hpos) != 32'(h / 2) || 32'(bus_b.o_vpos) != 32'(v / 2)) pos_err++;
      if (bus_b.o_display_on != ((h < 10) && (v < 6))) de_err++;
      if (bus_b.o_hsync == 1'b0) hs_low++;
      if (bus_b.o_vsync == 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = v;
        vs_last = v;
      end
      if (bus_b.o_line_tick) lt_cnt++;
      if (bus_b.o_frame_tick) begin
        ft_cnt++;
        ft_at = c;
      end
      step(1);
    end
    check("b_pos_err",     32'(pos_err), 32'd0);
    check("b_de_err",      32'(de_err), 32'd0);
    check("b_hsync_total", 32'(hs_low), 32'd30);
    check("b_vsync_len",   32'(vs_low), 32'd32);
    check("b_vsync_first", 32'(vs_first), 32'd7);
    check("b_vsync_last",  32'(vs_last), 32'd8);
    check("b_lt_count",    32'(lt_cnt), 32'd10);
    check("b_ft_count",    32'(ft_cnt), 32'd1);
    check("b_ft_at",       32'(ft_at), 32'd159);
    check("b_frame1",      32'(bus_b.o_frame), 32'd1);
    check("b_wrap_hpos",   32'(bus_b.o_hpos), 32'd0);
    check("b_wrap_vpos",   32'(bus_b.o_vpos), 32'd0);

    // ---------------- dut_b: CONV=1 slicing at (11,5) ----------------
    step(91);
    check("b_conv_hpos",  32'(bus_b.o_hpos), 32'd5);
    check("b_conv_vpos",  32'(bus_b.o_vpos), 32'd2);
    check("b_conv_de",    32'(bus_b.o_display_on), 32'd0);
    check("b_conv_hsync", 32'(bus_b.o_hsync), 32'd1);

    // ---------------- dut_b: reset mid-frame ----------------
    rst_b = 1'b1;
    step(1);
    rst_b = 1'b0;
    check("b_mrst_hpos",  32'(bus_b.o_hpos), 32'd0);
    check("b_mrst_vpos",  32'(bus_b.o_vpos), 32'd0);
    check("b_mrst_frame", 32'(bus_b.o_frame), 32'd0);
    check("b_mrst_hsync", 32'(bus_b.o_hsync), 32'd1);
    check("b_mrst_vsync", 32'(bus_b.o_vsync), 32'd1);
    check("b_mrst_ft",    32'(bus_b.o_frame_tick), 32'd0);

    // ---------------- dut_b: 256 frames, counter wrap ----------------
    ft_cnt = 0; ft_at = -1; frame_at_last = -1;
    for (int i = 0; i < 160 * 256; i++) begin
      if (bus_b.o_frame_tick) begin
        ft_cnt++;
        if (ft_at < 0) ft_at = i;
        if (ft_cnt == 256) frame_at_last = 32'(bus_b.o_frame);
      end
      step(1);
    end
    check("b_wrap_ticks",     32'(ft_cnt), 32'd256);
    check("b_first_tick",     32'(ft_at), 32'd159);
    check("b_frame_pre_wrap", 32'(frame_at_last), 32'd255);
    check("b_frame_wrapped",  32'(bus_b.o_frame), 32'd0);
    check("b_end_hpos",       32'(bus_b.o_hpos), 32'd0);
    check("b_end_vpos",       32'(bus_b.o_vpos), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator; the stage directly upstream of the background/sprite pixel stages.
- Produces the horizontal/vertical pixel position consumed as i_hpos/i_vpos by the colour stages (ground line, sprites), plus VGA hsync/vsync, display-enable, line/frame strobes and a free-running frame counter for game animation.
- One instance per design, clocked at the pixel clock (25.175/25 MHz for 640x480@60).

Parameters:
- CONV, 0, low bits dropped from the position outputs (position downscale by 2^CONV); outputs are [9:CONV], matching the colour stages.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BACK, 48, horizontal back porch, in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BACK, 33, vertical back porch, in lines.
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low, VGA 640x480 standard).

Ports:
- clk  input  1  pixel clock.
- rst  input  1  synchronous reset, active-high.
- o_hpos  output  [9:CONV]  horizontal position, hcount[9:CONV].
- o_vpos  output  [9:CONV]  vertical position, vcount[9:CONV].
- o_hsync  output  1  horizontal sync, level per SYNC_POL.
- o_vsync  output  1  vertical sync, level per SYNC_POL.
- o_display_on  output  1  high while hcount < H_DISPLAY and vcount < V_DISPLAY.
- o_line_tick  output  1  one-cycle pulse on the last pixel of every line.
- o_frame_tick  output  1  one-cycle pulse on the last pixel of the last line of each frame.
- o_frame  output  8  frame counter; increments once per frame and wraps 255->0.

Behaviour:
- Internal counters: hcount and vcount, 10 bits each, registered.
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Every clk with rst=0:
  - hcount increments by 1.
  - When hcount == H_TOTAL-1: hcount <= 0 and vcount increments.
  - When also vcount == V_TOTAL-1: vcount <= 0 and o_frame <= o_frame+1 (mod 256).
- vcount changes only on the cycle hcount wraps.
- o_hpos/o_vpos are pure bit-slices of the registered counters (zero latency); no rounding at the CONV boundary.
- o_hsync and o_vsync are registered. Each register is loaded from the next-state counter values, so it aligns with the hcount/vcount that produced it and is glitch-free.
  - hsync is active for H_DISPLAY+H_FRONT <= hcount < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - vsync is active for V_DISPLAY+V_FRONT <= vcount < V_DISPLAY+V_FRONT+V_SYNC (490..491), across the full line width.
- o_display_on, o_line_tick and o_frame_tick are combinational decodes of the registered counters.
- Reset (synchronous, overrides everything):
  - hcount=0, vcount=0, o_frame=0.
  - o_hsync=o_vsync=~SYNC_POL (inactive).
  - Resulting decodes: o_display_on=1, o_line_tick=0, o_frame_tick=0.
  - First post-reset cycle presents pixel (0,0).
- Reset mid-frame: the next cycle after rst is asserted shows hcount=vcount=0 and sync inactive. No partial-line completion; no tick is emitted for the aborted frame.
- Wrap-around: hcount never reaches H_TOTAL and vcount never reaches V_TOTAL. On simultaneous h/v wrap, both tick outputs are high in the same cycle.
- Counters must not depend on the value of CONV.

Test Plan:
1. Hold rst 3 cycles then release -> during rst and the first cycle after release: hpos=0, vpos=0, hsync=vsync=1, display_on=1, frame=0; next cycle hpos=1.
2. Run one line (CONV=0) -> hsync low exactly for hcount 656..751 (96 cycles); display_on falls at hcount=640; line_tick high only at hcount=799; the following cycle shows hpos=0, vpos=1.
3. Run one full frame (420000 cycles) -> vsync low only on lines 490..491 (1600 cycles); frame_tick single pulse at (799,524); next cycle (0,0) with frame=1.
4. Run 256 frames -> frame wraps from 255 back to 0 on the 256th frame_tick.
5. CONV=1 build at hcount=641, vcount=479 -> o_hpos=320, o_vpos=239; a downstream ground-line stage with GND_LINE=239 lights the entire line.
6. Assert rst at hcount=300, vcount=200 for 1 cycle -> next cycle (0,0), sync inactive, frame=0, no frame_tick emitted; normal counting resumes.
